receiver: RTL and testbench

RECEIVER -- requirements
Module: receiver

---
 rtl/receiver_pkg.sv | 14 +
 rtl/receiver.sv | 91 +++++++++
 tb/tb_receiver.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/receiver_pkg.sv
// Shared types and defaults for the serial frame receiver.
// Frame layout: start(0), data bits LSB first, parity, stop(1).
package receiver_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

endpackage

// File: rtl/receiver.sv
// Serial frame receiver, one bit per clk: start, DATA_W data bits LSB first,
// parity, stop. The byte is committed to data_bus on a clean stop sample.
module receiver
  import receiver_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              data_in,
  output logic [DATA_W-1:0] data_bus,
  output logic              busy,
  output logic              err
);

  localparam int                CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);
  localparam bit                ODD   = (ODD_PARITY != 0);

  state_t              state, state_next;
  logic [CNT_W-1:0]    count, count_next;
  logic [DATA_W-1:0]   shreg, shreg_next;
  logic [DATA_W-1:0]   bus_next;
  logic                par_ok, par_ok_next;
  logic                err_next;

  always_comb begin
    state_next  = state;
    count_next  = count;
    shreg_next  = shreg;
    par_ok_next = par_ok;
    bus_next    = data_bus;
    err_next    = err;
    // Dropping enable aborts any frame in flight without touching outputs.
    if (!enable) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (!data_in) begin
            state_next = DATA;
            count_next = '0;
          end
        end
        DATA: begin
          shreg_next[count] = data_in;
          if (count == LAST) state_next = PARITY;
          else               count_next = count + 1'b1;
        end
        PARITY: begin
          par_ok_next = (data_in == ((^shreg) ^ ODD));
          state_next  = STOP;
        end
        STOP: begin
          if (par_ok && data_in) begin
            bus_next = shreg;
            err_next = 1'b0;
          end else begin
            err_next = 1'b1;
          end
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      shreg    <= '0;
      par_ok   <= 1'b0;
      data_bus <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      shreg    <= shreg_next;
      par_ok   <= par_ok_next;
      data_bus <= bus_next;
      // busy is registered from the next state so it tracks state exactly.
      busy     <= (state_next != IDLE);
      err      <= err_next;
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for receiver: expected outputs queued per frame, observed
// outputs captured when busy falls, then compared in each scenario task.
module tb_receiver;
  import receiver_pkg::*;

  typedef struct { logic [7:0] bus; logic err; } exp_t;
  typedef struct { logic [7:0] bus; logic err; int len; } obs_t;

  logic       clk = 1'b0;
  logic       rst, enable, data_in;
  logic [7:0] data_bus;
  logic       busy, err;

  int   checks = 0, failures = 0;
  exp_t exp_q[$];
  obs_t obs_q[$];
  int   rd = 0;
  logic [7:0] m_bus = 8'h00;
  logic       m_err = 1'b0;

  receiver #(.DATA_W(8), .ODD_PARITY(0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .data_in(data_in),
    .data_bus(data_bus), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Capture outputs and busy length every time a frame ends (busy falls).
  int blen = 0;
  bit prev_busy = 1'b0;
  always @(negedge clk) begin
    obs_t o;
    if (busy === 1'b1) blen++;
    else if (prev_busy) begin
      o.bus = data_bus; o.err = err; o.len = blen;
      obs_q.push_back(o);
      blen = 0;
    end
    prev_busy = (busy === 1'b1);
  end

  task automatic drive(input logic b);
    @(negedge clk);
    data_in = b;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1);
  endtask

  task automatic push_exp();
    exp_t e;
    e.bus = m_bus; e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    if ((par == ^d) && stp) begin m_bus = d; m_err = 1'b0; end
    else m_err = 1'b1;
    push_exp();
    drive(1'b0);
    for (int i = 0; i < 8; i++) drive(d[i]);
    drive(par);
    drive(stp);
  endtask

  // Waits (bounded) for the next observation; an expired bound counts as a failure.
  task automatic wait_obs(output bit got, output obs_t o, output exp_t e);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (obs_q.size() > rd) begin got = 1'b1; break; end
      @(negedge clk); #1;
    end
    e = exp_q.pop_front();
    if (got) begin o = obs_q[rd]; rd++; end
    else begin
      o.bus = 8'hxx; o.err = 1'bx; o.len = -1;
      checks++; failures++;
      $display("FAIL frame_timeout: no end of frame seen, expected bus=%h", e.bus);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; data_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    checks++; if (data_bus !== 8'h00) begin failures++; $display("FAIL reset_bus: got %h want 00", data_bus); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d want IDLE", dut.state); end
  endtask

  task automatic test_good_frame();
    bit got; obs_t o; exp_t e;
    enable = 1'b1;
    idle(3);
    send_frame(8'hAE, 1'b1, 1'b1);
    idle(2);
    wait_obs(got, o, e);
    if (got) begin
      checks++; if (o.bus !== 8'hAE || o.bus !== e.bus) begin failures++; $display("FAIL good_bus: got %h want AE", o.bus); end
      checks++; if (o.err !== e.err) begin failures++; $display("FAIL good_err: got %b want %b", o.err, e.err); end
      checks++; if (o.len !== 10) begin failures++; $display("FAIL good_busy_len: got %0d want 10", o.len); end
    end
  endtask

  task automatic test_bad_parity();
    bit got; obs_t o; exp_t e;
    send_frame(8'h55, 1'b1, 1'b1);
    idle(2);
    wait_obs(got, o, e);
    if (got) begin
      checks++; if (o.err !== 1'b1) begin failures++; $display("FAIL parity_err: got %b want 1", o.err); end
      checks++; if (o.bus !== e.bus) begin failures++; $display("FAIL parity_bus: got %h want %h", o.bus, e.bus); end
    end
  endtask

  task automatic test_framing();
    bit got; obs_t o; exp_t e;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(2);
    send_frame(8'h01, 1'b1, 1'b1);
    idle(2);
    wait_obs(got, o, e);
    if (got) begin
      checks++; if (o.err !== 1'b1) begin failures++; $display("FAIL framing_err: got %b want 1", o.err); end
      checks++; if (o.bus !== e.bus) begin failures++; $display("FAIL framing_bus: got %h want %h", o.bus, e.bus); end
    end
    wait_obs(got, o, e);
    if (got) begin
      checks++; if (o.bus !== e.bus) begin failures++; $display("FAIL recover_bus: got %h want %h", o.bus, e.bus); end
      checks++; if (o.err !== e.err) begin failures++; $display("FAIL recover_err: got %b want %b", o.err, e.err); end
    end
  endtask

  task automatic test_abort();
    bit got; obs_t o; exp_t e;
    logic [7:0] d;
    d = 8'h96;
    push_exp();
    drive(1'b0);
    for (int i = 0; i < 4; i++) drive(d[i]);
    @(negedge clk); enable = 1'b0; data_in = 1'b1;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", busy); end
    wait_obs(got, o, e);
    if (got) begin
      checks++; if (o.bus !== e.bus) begin failures++; $display("FAIL abort_bus: got %h want %h", o.bus, e.bus); end
      checks++; if (o.err !== e.err) begin failures++; $display("FAIL abort_err: got %b want %b", o.err, e.err); end
    end
    idle(2);
    enable = 1'b1;
    idle(2);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle(2);
    wait_obs(got, o, e);
    if (got) begin
      checks++; if (o.bus !== 8'hFF || o.bus !== e.bus) begin failures++; $display("FAIL after_abort_bus: got %h want FF", o.bus); end
      checks++; if (o.err !== 1'b0) begin failures++; $display("FAIL after_abort_err: got %b want 0", o.err); end
    end
  endtask

  task automatic test_back_to_back();
    bit got; obs_t o; exp_t e;
    send_frame(8'hA5, 1'b0, 1'b1);
    send_frame(8'h3F, 1'b0, 1'b1);
    idle(2);
    wait_obs(got, o, e);
    if (got) begin
      checks++; if (o.bus !== e.bus) begin failures++; $display("FAIL b2b_first_bus: got %h want %h", o.bus, e.bus); end
    end
    wait_obs(got, o, e);
    if (got) begin
      checks++; if (o.bus !== e.bus) begin failures++; $display("FAIL b2b_second_bus: got %h want %h", o.bus, e.bus); end
      checks++; if (o.err !== e.err) begin failures++; $display("FAIL b2b_second_err: got %b want %b", o.err, e.err); end
      checks++; if (o.len !== 10) begin failures++; $display("FAIL b2b_busy_len: got %0d want 10", o.len); end
    end
  endtask

  task automatic test_reset_midframe();
    bit got; obs_t o; exp_t e;
    logic [7:0] d;
    d = 8'h5A;
    drive(1'b0);
    for (int i = 0; i < 3; i++) drive(d[i]);
    #2;
    m_bus = 8'h00; m_err = 1'b0;
    push_exp();
    rst = 1'b1;
    #1;
    checks++; if (data_bus !== 8'h00 || busy !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL async_reset: got bus=%h busy=%b err=%b want 00/0/0", data_bus, busy, err);
    end
    for (int i = 3; i < 8; i++) drive(d[i]);
    drive(1'b0);
    drive(1'b1);
    @(negedge clk); rst = 1'b0;
    idle(3);
    #1;
    checks++; if (busy !== 1'b0 || data_bus !== 8'h00) begin
      failures++; $display("FAIL post_reset_idle: got busy=%b bus=%h want 0/00", busy, data_bus);
    end
    wait_obs(got, o, e);
    if (got) begin
      checks++; if (o.bus !== e.bus || o.err !== e.err) begin failures++; $display("FAIL reset_frame_out: got %h/%b want %h/%b", o.bus, o.err, e.bus, e.err); end
    end
    send_frame(8'hC3, 1'b0, 1'b1);
    idle(2);
    wait_obs(got, o, e);
    if (got) begin
      checks++; if (o.bus !== e.bus || o.err !== e.err) begin failures++; $display("FAIL after_reset_frame: got %h/%b want %h/%b", o.bus, o.err, e.bus, e.err); end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; data_in = 1'b1;
    test_reset();
    test_good_frame();
    test_bad_parity();
    test_framing();
    test_abort();
    test_back_to_back();
    test_reset_midframe();
    checks++;
    if (obs_q.size() != rd) begin
      failures++; $display("FAIL extra_frames: got %0d observed want %0d", obs_q.size(), rd);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
